// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// default operand width and the iteration-counter width helper.
package seq_divider_pkg;

    localparam int DEFAULT_BITS = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Counter must be able to hold the value bits itself, not just bits-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle of the sequential divider. The div_by_zero flag
// exists only when DIV_BY_ZERO_FLAG_EN is defined.
interface seq_divider_if
    import seq_divider_pkg::*;
#(
    parameter int bits = DEFAULT_BITS
);

    logic            start;
    logic [bits-1:0] dividend;
    logic [bits-1:0] divisor;
    logic [bits-1:0] quotient;
    logic [bits-1:0] remainder;
    logic            busy;
    logic            done;
`ifdef DIV_BY_ZERO_FLAG_EN
    logic            div_by_zero;
`endif

    modport master (
        output start, dividend, divisor,
`ifdef DIV_BY_ZERO_FLAG_EN
        input  div_by_zero,
`endif
        input  quotient, remainder, busy, done
    );

    modport slave (
        input  start, dividend, divisor,
`ifdef DIV_BY_ZERO_FLAG_EN
        output div_by_zero,
`endif
        output quotient, remainder, busy, done
    );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, then
// compare against the divisor and subtract when it fits.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int bits = DEFAULT_BITS
) (
    input  logic [bits:0]   rem_in,
    input  logic            in_bit,
    input  logic [bits-1:0] divisor,
    output logic [bits:0]   rem_out,
    output logic            q_bit
);

    // One bit wider than the partial remainder so the shift can never lose
    // a bit before the comparison is made.
    logic [bits+1:0] shifted;

    assign shifted = {rem_in, in_bit};
    assign q_bit   = (shifted >= {2'b00, divisor});
    assign rem_out = q_bit ? (bits+1)'(shifted - {2'b00, divisor})
                           : (bits+1)'(shifted);

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// Optional DIV_BY_ZERO_FLAG_EN adds a one-cycle divide-by-zero shortcut and flag.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int bits = DEFAULT_BITS
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);

    localparam int CNT_W = cnt_width(bits);

    state_t          state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [bits:0]   rem_reg;
    logic [bits-1:0] dq_reg;
    logic [bits-1:0] dvs_reg;
    logic [bits-1:0] quotient_reg;
    logic [bits-1:0] remainder_reg;
    logic            busy_reg;
    logic            done_reg;
`ifdef DIV_BY_ZERO_FLAG_EN
    logic            dbz_reg;
`endif

    logic [bits:0]   step_rem;
    logic            step_q;
    logic            last_step;

    div_step #(.bits(bits)) u_step (
        .rem_in  (rem_reg),
        .in_bit  (dq_reg[bits-1]),
        .divisor (dvs_reg),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    assign cnt_next  = cnt_reg + 1'b1;
    assign last_step = (cnt_next == CNT_W'(bits));

    // dq_reg shifts the dividend out at the top while quotient bits enter at
    // the bottom, so the results only reach the output registers at the end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            rem_reg       <= '0;
            dq_reg        <= '0;
            dvs_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
`ifdef DIV_BY_ZERO_FLAG_EN
            dbz_reg       <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg <= BUSY;
                        busy_reg  <= 1'b1;
                        cnt_reg   <= '0;
                        rem_reg   <= '0;
                        dq_reg    <= bus.dividend;
                        dvs_reg   <= bus.divisor;
                    end
                end
                BUSY: begin
`ifdef DIV_BY_ZERO_FLAG_EN
                    if (dvs_reg == '0) begin
                        // dq_reg still holds the untouched dividend here.
                        quotient_reg  <= '1;
                        remainder_reg <= dq_reg;
                        dbz_reg       <= 1'b1;
                        done_reg      <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end else
`endif
                    begin
                        rem_reg <= step_rem;
                        dq_reg  <= {dq_reg[bits-2:0], step_q};
                        cnt_reg <= cnt_next;
                        if (last_step) begin
                            quotient_reg  <= {dq_reg[bits-2:0], step_q};
                            remainder_reg <= step_rem[bits-1:0];
                            done_reg      <= 1'b1;
                            busy_reg      <= 1'b0;
                            state_reg     <= IDLE;
`ifdef DIV_BY_ZERO_FLAG_EN
                            dbz_reg       <= 1'b0;
`endif
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.quotient  = quotient_reg;
    assign bus.remainder = remainder_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
`ifdef DIV_BY_ZERO_FLAG_EN
    assign bus.div_by_zero = dbz_reg;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (8-bit), builds with or without
// DIV_BY_ZERO_FLAG_EN; expectations come from plain integer division.
module tb_seq_divider;
    import seq_divider_pkg::*;

    localparam int BITS = 8;
`ifdef DIV_BY_ZERO_FLAG_EN
    localparam bit DBZ_EN = 1'b1;
`else
    localparam bit DBZ_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    seq_divider_if #(.bits(BITS)) bus ();

    seq_divider #(.bits(BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic dbz_now();
`ifdef DIV_BY_ZERO_FLAG_EN
        return bus.div_by_zero;
`else
        return 1'b0;
`endif
    endfunction

    // Reference: ordinary integer division; divide by zero gives all ones / dividend.
    function automatic void model(input int a, input int b, output int q, output int r);
        if (b == 0) begin
            q = (1 << BITS) - 1;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic int model_cycles(input int b);
        return (DBZ_EN && b == 0) ? 1 : BITS;
    endfunction

    // Called at a negedge with the divider idle; returns at the negedge of the done cycle.
    task automatic do_op(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                         output int cyc, output int q, output int r,
                         output logic dz, output logic bsy);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                cyc = k;
                break;
            end
        end
        q   = int'(bus.quotient);
        r   = int'(bus.remainder);
        dz  = dbz_now();
        bsy = bus.busy;
        $display("op %0d/%0d -> q=%0d r=%0d dbz=%0d cycles=%0d", a, b, q, r, dz, cyc);
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
        total++; if (bus.quotient !== 8'd0) begin bad++; $display("FAIL reset_quotient got=%0d want=0", bus.quotient); end
        total++; if (bus.remainder !== 8'd0) begin bad++; $display("FAIL reset_remainder got=%0d want=0", bus.remainder); end
        total++; if (dbz_now() !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b want=0", dbz_now()); end
        rst = 1'b0;
        @(negedge clk);
        $display("reset checked");
    endtask

    task automatic test_directed();
        logic [BITS-1:0] ta [4] = '{8'd100, 8'd5, 8'd255, 8'd255};
        logic [BITS-1:0] tb [4] = '{8'd7, 8'd9, 8'd1, 8'd255};
        int eq [4] = '{14, 0, 255, 1};
        int er [4] = '{2, 5, 0, 0};
        int cyc, q, r;
        logic dz, bsy;
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], cyc, q, r, dz, bsy);
            total++; if (cyc != BITS) begin bad++; $display("FAIL dir%0d_cycles got=%0d want=%0d", i, cyc, BITS); end
            total++; if (q != eq[i]) begin bad++; $display("FAIL dir%0d_quotient got=%0d want=%0d", i, q, eq[i]); end
            total++; if (r != er[i]) begin bad++; $display("FAIL dir%0d_remainder got=%0d want=%0d", i, r, er[i]); end
            total++; if (bsy !== 1'b0) begin bad++; $display("FAIL dir%0d_busy got=%b want=0", i, bsy); end
            total++; if (dz !== 1'b0) begin bad++; $display("FAIL dir%0d_dbz got=%b want=0", i, dz); end
        end
        @(negedge clk);
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL done_single_cycle got=%b want=0", bus.done); end
    endtask

    task automatic test_div_zero();
        int cyc, q, r;
        logic dz, bsy;
        do_op(8'd37, 8'd0, cyc, q, r, dz, bsy);
        total++; if (cyc != model_cycles(0)) begin bad++; $display("FAIL dbz_cycles got=%0d want=%0d", cyc, model_cycles(0)); end
        total++; if (q != 255) begin bad++; $display("FAIL dbz_quotient got=%0d want=255", q); end
        total++; if (r != 37) begin bad++; $display("FAIL dbz_remainder got=%0d want=37", r); end
        total++; if (dz !== DBZ_EN) begin bad++; $display("FAIL dbz_flag got=%b want=%b", dz, DBZ_EN); end
        total++; if (bsy !== 1'b0) begin bad++; $display("FAIL dbz_busy got=%b want=0", bsy); end
        // A following successful divide must clear the flag again.
        do_op(8'd20, 8'd6, cyc, q, r, dz, bsy);
        total++; if (dz !== 1'b0) begin bad++; $display("FAIL dbz_clear got=%b want=0", dz); end
        total++; if (q != 3 || r != 2) begin bad++; $display("FAIL dbz_next got=%0d r %0d want=3 r 2", q, r); end
    endtask

    task automatic test_busy_ignore();
        int cyc = -1;
        bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin cyc = k; break; end
            if (k == 2) begin bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 8'd9; end
            if (k == 3) begin
                bus.start = 1'b0;
                total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL ignore_busy got=%b want=1", bus.busy); end
                total++; if (bus.quotient !== 8'd3) begin bad++; $display("FAIL ignore_hold got=%0d want=3", bus.quotient); end
            end
        end
        $display("op 200/3 with ignored 9/9 -> q=%0d r=%0d cycles=%0d", bus.quotient, bus.remainder, cyc);
        total++; if (cyc != BITS) begin bad++; $display("FAIL ignore_cycles got=%0d want=%0d", cyc, BITS); end
        total++; if (bus.quotient !== 8'd66) begin bad++; $display("FAIL ignore_quotient got=%0d want=66", bus.quotient); end
        total++; if (bus.remainder !== 8'd2) begin bad++; $display("FAIL ignore_remainder got=%0d want=2", bus.remainder); end
    endtask

    task automatic test_reset_mid();
        int cyc, q, r, dones;
        logic dz, bsy;
        bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", bus.busy); end
        total++; if (bus.quotient !== 8'd0 || bus.remainder !== 8'd0) begin
            bad++; $display("FAIL midrst_outputs got=%0d r %0d want=0 r 0", bus.quotient, bus.remainder); end
        dones = 0;
        repeat (2) begin @(negedge clk); if (bus.done === 1'b1) dones++; end
        rst = 1'b0;
        repeat (12) begin @(negedge clk); if (bus.done === 1'b1 || bus.busy === 1'b1) dones++; end
        total++; if (dones != 0) begin bad++; $display("FAIL midrst_no_done got=%0d want=0", dones); end
        do_op(8'd50, 8'd4, cyc, q, r, dz, bsy);
        total++; if (cyc != BITS) begin bad++; $display("FAIL midrst_cycles got=%0d want=%0d", cyc, BITS); end
        total++; if (q != 12 || r != 2) begin bad++; $display("FAIL midrst_result got=%0d r %0d want=12 r 2", q, r); end
    endtask

    task automatic test_back_to_back();
        int c1 = -1, c2 = -1, q1 = -1, r1 = -1, q2 = -1, r2 = -1, n = 0;
        bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
        @(negedge clk);
        bus.dividend = 8'd81; bus.divisor = 8'd9;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (c1 > 0 && k == c1 + 1) begin
                total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL b2b_pulse got=%b want=0", bus.done); end
            end
            if (bus.done === 1'b1) begin
                n++;
                if (n == 1) begin c1 = k; q1 = int'(bus.quotient); r1 = int'(bus.remainder); end
                else begin c2 = k; q2 = int'(bus.quotient); r2 = int'(bus.remainder); bus.start = 1'b0; break; end
            end
        end
        bus.start = 1'b0;
        $display("b2b 100/7 -> %0d r %0d at %0d, 81/9 -> %0d r %0d at %0d", q1, r1, c1, q2, r2, c2);
        total++; if (c1 != BITS) begin bad++; $display("FAIL b2b_first_cycle got=%0d want=%0d", c1, BITS); end
        total++; if (c2 - c1 != BITS + 1) begin bad++; $display("FAIL b2b_gap got=%0d want=%0d", c2 - c1, BITS + 1); end
        total++; if (q1 != 14 || r1 != 2) begin bad++; $display("FAIL b2b_first got=%0d r %0d want=14 r 2", q1, r1); end
        total++; if (q2 != 9 || r2 != 0) begin bad++; $display("FAIL b2b_second got=%0d r %0d want=9 r 0", q2, r2); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int prev_q, prev_r, eq, er, cyc;
        int a, b;
        model(13, 5, prev_q, prev_r);
        begin
            int q, r; logic dz, bsy;
            do_op(8'd13, 8'd5, cyc, q, r, dz, bsy);
            total++; if (q != prev_q || r != prev_r) begin bad++; $display("FAIL rnd_seed got=%0d r %0d want=%0d r %0d", q, r, prev_q, prev_r); end
        end
        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            model(a, b, eq, er);
            bus.start = 1'b1; bus.dividend = a[7:0]; bus.divisor = b[7:0];
            @(negedge clk);
            bus.start = 1'b0;
            bus.dividend = 8'($urandom); bus.divisor = 8'($urandom);
            cyc = -1;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (bus.done === 1'b1) begin cyc = k; break; end
                total++; if (bus.quotient !== 8'(prev_q) || bus.remainder !== 8'(prev_r)) begin
                    bad++; $display("FAIL rnd%0d_hold got=%0d r %0d want=%0d r %0d", i, bus.quotient, bus.remainder, prev_q, prev_r); end
            end
            $display("op %0d/%0d -> q=%0d r=%0d cycles=%0d", a, b, bus.quotient, bus.remainder, cyc);
            total++; if (cyc != model_cycles(b)) begin bad++; $display("FAIL rnd%0d_cycles got=%0d want=%0d", i, cyc, model_cycles(b)); end
            total++; if (bus.quotient !== 8'(eq) || bus.remainder !== 8'(er)) begin
                bad++; $display("FAIL rnd%0d_result got=%0d r %0d want=%0d r %0d", i, bus.quotient, bus.remainder, eq, er); end
            total++; if (dbz_now() !== (DBZ_EN && b == 0)) begin
                bad++; $display("FAIL rnd%0d_dbz got=%b want=%b", i, dbz_now(), (DBZ_EN && b == 0)); end
            total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rnd%0d_busy got=%b want=0", i, bus.busy); end
            prev_q = eq;
            prev_r = er;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

endmodule
